// File: rtl/dac_spi_multichannel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dac_spi_multichannel
// Brief    : Avalon-ST sample sink to multi-channel SPI DAC writer with
//            chip-select gap, optional LDAC simultaneous update, drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_multichannel #(
    parameter int DATA_WIDTH    = 12,
    parameter int NUM_CHANNELS  = 2,
    parameter int CS_GAP_CYCLES = 2,
    parameter int SYNC_UPDATE   = 0
) (
    input  logic                  sclk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] ast_sink_data,
    input  logic [1:0]            ast_sink_channel,
    input  logic                  ast_sink_valid,
    input  logic [1:0]            ast_sink_error,
    output logic                  ast_sink_ready,
    output logic                  cs_n,
    output logic                  mosi,
    output logic                  clr_n,
    output logic                  ldac_n,
    output logic                  busy,
    output logic [7:0]            drop_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_LDAC  = 2'd3;

    localparam int               c_gap_w    = (CS_GAP_CYCLES > 1) ? $clog2(CS_GAP_CYCLES) : 1;
    localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(CS_GAP_CYCLES - 1);
    localparam logic [3:0]       c_cmd      = (SYNC_UPDATE != 0) ? 4'b0000 : 4'b0011;
    localparam logic [2:0]       c_num_ch   = 3'(NUM_CHANNELS);
    localparam logic [1:0]       c_last_ch  = 2'(NUM_CHANNELS - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [4:0]            r_bit_cnt;
    logic [c_gap_w-1:0]    r_gap_cnt;
    logic [31:0]           r_shift;
    logic [1:0]            r_chan;
    logic                  r_cs_n;
    logic                  r_mosi;
    logic                  r_clr_n;
    logic                  r_ldac_n;
    logic [7:0]            r_drop_count;

    logic                  w_accept;
    logic                  w_bad;
    logic                  w_good;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_u;
    logic [31:0]           w_frame;

    assign ast_sink_ready = (r_state == S_IDLE) && en && !reset;
    assign busy           = (r_state != S_IDLE);
    assign cs_n           = r_cs_n;
    assign mosi           = r_mosi;
    assign clr_n          = r_clr_n;
    assign ldac_n         = r_ldac_n;
    assign drop_count     = r_drop_count;

    assign w_accept = ast_sink_valid && ast_sink_ready;
    assign w_bad    = (|ast_sink_error) || ({1'b0, ast_sink_channel} >= c_num_ch);
    assign w_good   = w_accept && !w_bad;
    assign w_drop   = w_accept && w_bad;

    // Inverting the sign bit maps two's complement onto offset binary.
    assign w_u     = {~ast_sink_data[DATA_WIDTH-1], ast_sink_data[DATA_WIDTH-2:0]};
    assign w_frame = {4'h0, c_cmd, 2'b00, ast_sink_channel, w_u, {(20-DATA_WIDTH){1'b0}}};

    always_ff @(posedge sclk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_good) w_next_state = S_SHIFT;
            S_SHIFT: if (r_bit_cnt == 5'd0) w_next_state = S_GAP;
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    if ((SYNC_UPDATE != 0) && (r_chan == c_last_ch)) w_next_state = S_LDAC;
                    else                                             w_next_state = S_IDLE;
                end
            end
            S_LDAC:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            r_bit_cnt    <= 5'd0;
            r_gap_cnt    <= '0;
            r_shift      <= 32'd0;
            r_chan       <= 2'd0;
            r_cs_n       <= 1'b1;
            r_mosi       <= 1'b0;
            r_clr_n      <= 1'b0;
            r_ldac_n     <= 1'b1;
            r_drop_count <= 8'd0;
        end else begin
            r_clr_n  <= 1'b1;
            r_cs_n   <= (r_state != S_SHIFT);
            r_mosi   <= (r_state == S_SHIFT) && r_shift[31];
            r_ldac_n <= (r_state != S_LDAC);
            case (r_state)
                S_IDLE: begin
                    if (w_good) begin
                        r_shift   <= w_frame;
                        r_chan    <= ast_sink_channel;
                        r_bit_cnt <= 5'd31;
                    end
                end
                S_SHIFT: begin
                    r_shift   <= {r_shift[30:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt - 5'd1;
                    if (r_bit_cnt == 5'd0) r_gap_cnt <= c_gap_load;
                end
                S_GAP: begin
                    if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
                end
                default: ;
            endcase
            if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_multichannel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dac_spi_multichannel
// Brief    : Scoreboard bench for two DUT configurations (plain and LDAC).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_spi_multichannel;

    typedef struct packed {
        logic [31:0] frame;
        logic        ldac;
    } exp_t;

    logic             sclk = 1'b0;
    logic [1:0]       rst_v;
    logic [1:0]       en_v;
    logic [1:0]       valid_v;
    logic [1:0][15:0] data_v;
    logic [1:0][1:0]  ch_v;
    logic [1:0][1:0]  err_v;

    logic ready_a, cs_a, mosi_a, clr_a, ldac_a, busy_a;
    logic ready_b, cs_b, mosi_b, clr_b, ldac_b, busy_b;
    logic [7:0] drop_a, drop_b;
    logic [1:0] ready_v, cs_v, mosi_v, clr_v, ldac_v, busy_v;

    assign ready_v = {ready_b, ready_a};
    assign cs_v    = {cs_b, cs_a};
    assign mosi_v  = {mosi_b, mosi_a};
    assign clr_v   = {clr_b, clr_a};
    assign ldac_v  = {ldac_b, ldac_a};
    assign busy_v  = {busy_b, busy_a};

    always #5 sclk = ~sclk;

    dac_spi_multichannel #(
        .DATA_WIDTH(12), .NUM_CHANNELS(2), .CS_GAP_CYCLES(2), .SYNC_UPDATE(0)
    ) u_dut_a (
        .sclk(sclk), .reset(rst_v[0]), .en(en_v[0]),
        .ast_sink_data(data_v[0][11:0]), .ast_sink_channel(ch_v[0]),
        .ast_sink_valid(valid_v[0]), .ast_sink_error(err_v[0]),
        .ast_sink_ready(ready_a), .cs_n(cs_a), .mosi(mosi_a), .clr_n(clr_a),
        .ldac_n(ldac_a), .busy(busy_a), .drop_count(drop_a)
    );

    dac_spi_multichannel #(
        .DATA_WIDTH(16), .NUM_CHANNELS(3), .CS_GAP_CYCLES(3), .SYNC_UPDATE(1)
    ) u_dut_b (
        .sclk(sclk), .reset(rst_v[1]), .en(en_v[1]),
        .ast_sink_data(data_v[1]), .ast_sink_channel(ch_v[1]),
        .ast_sink_valid(valid_v[1]), .ast_sink_error(err_v[1]),
        .ast_sink_ready(ready_b), .cs_n(cs_b), .mosi(mosi_b), .clr_n(clr_b),
        .ldac_n(ldac_b), .busy(busy_b), .drop_count(drop_b)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int model_drop[2] = '{0, 0};
    exp_t q0[$];
    exp_t q1[$];

    int in_frame[2]   = '{0, 0};
    int nbits[2]      = '{0, 0};
    int high_cnt[2]   = '{0, 0};
    int have_prev[2]  = '{0, 0};
    int pend_ldac[2]  = '{0, 0};
    int last_gap[2]   = '{0, 0};
    int abort_flag[2] = '{0, 0};
    logic [31:0] bits_r[2];

    function automatic int p_dw(input int d);   return (d == 0) ? 12 : 16; endfunction
    function automatic int p_nc(input int d);   return (d == 0) ? 2 : 3;   endfunction
    function automatic int p_g(input int d);    return (d == 0) ? 2 : 3;   endfunction
    function automatic int p_sync(input int d); return (d == 0) ? 0 : 1;   endfunction
    function automatic logic [7:0] drop_of(input int d); return (d == 0) ? drop_a : drop_b; endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop(input int d, output exp_t e);
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    task automatic chk(input int d, input bit ok, input string name, input longint act, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL dut%0d %s: actual=0x%0h expected=0x%0h t=%0t", d, name, act, exp, $time);
        end
    endtask

    // Reference frame built arithmetically from the signed sample value.
    function automatic logic [31:0] model_frame(input int d, input int sv, input int ch);
        int dw;
        int u;
        int cmd;
        dw  = p_dw(d);
        u   = (sv + (1 << (dw - 1))) % (1 << dw);
        cmd = (p_sync(d) != 0) ? 0 : 3;
        return 32'((cmd << 24) + (ch << 20) + (u << (20 - dw)));
    endfunction

    task automatic send(input int d, input int raw, input int ch, input int err, input bit hold);
        int w;
        int dw;
        int sv;
        exp_t e;
        w  = 0;
        dw = p_dw(d);
        data_v[d]  = 16'(raw);
        ch_v[d]    = 2'(ch);
        err_v[d]   = 2'(err);
        valid_v[d] = 1'b1;
        #1;
        while (ready_v[d] !== 1'b1 && w < 500) begin
            @(negedge sclk);
            #1;
            w++;
        end
        chk(d, ready_v[d] === 1'b1, "accept_timeout", w, 0);
        if (ready_v[d] !== 1'b1) begin
            valid_v[d] = 1'b0;
            return;
        end
        @(posedge sclk);
        if (err != 0 || ch >= p_nc(d)) begin
            model_drop[d] = (model_drop[d] < 255) ? model_drop[d] + 1 : 255;
        end else begin
            sv = (raw >= (1 << (dw - 1))) ? raw - (1 << dw) : raw;
            e.frame = model_frame(d, sv, ch);
            e.ldac  = (p_sync(d) != 0) && (ch == p_nc(d) - 1);
            push(d, e);
        end
        @(negedge sclk);
        chk(d, drop_of(d) == 8'(model_drop[d]), "drop_count", drop_of(d), model_drop[d]);
        if (!hold) valid_v[d] = 1'b0;
    endtask

    task automatic check_reset_vals(input int d);
        chk(d, cs_v[d] == 1'b1,    "rst_cs_n",  cs_v[d], 1);
        chk(d, mosi_v[d] == 1'b0,  "rst_mosi",  mosi_v[d], 0);
        chk(d, ldac_v[d] == 1'b1,  "rst_ldac_n", ldac_v[d], 1);
        chk(d, clr_v[d] == 1'b0,   "rst_clr_n", clr_v[d], 0);
        chk(d, busy_v[d] == 1'b0,  "rst_busy",  busy_v[d], 0);
        chk(d, ready_v[d] == 1'b0, "rst_ready", ready_v[d], 0);
        chk(d, drop_of(d) == 8'd0, "rst_drop",  drop_of(d), 0);
    endtask

    task automatic rand_run(input int d, input int n);
        int raw;
        int ch;
        int err;
        bit hold;
        for (int i = 0; i < n; i++) begin
            raw  = int'($urandom_range(0, (1 << p_dw(d)) - 1));
            ch   = int'($urandom_range(0, 3));
            err  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            hold = ($urandom_range(0, 2) == 0);
            send(d, raw, ch, err, hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge sclk);
        end
        valid_v[d] = 1'b0;
    endtask

    // Monitor: rebuilds frames from the pins and checks framing/LDAC timing.
    task automatic mon_step(input int d);
        exp_t e;
        bit   ldac_exp;
        if (!cs_v[d]) begin
            if (in_frame[d] == 0) begin
                in_frame[d] = 1;
                nbits[d]    = 0;
                bits_r[d]   = 32'd0;
                if (have_prev[d] != 0) begin
                    last_gap[d] = high_cnt[d];
                    chk(d, high_cnt[d] >= p_g(d) + 1, "cs_gap", high_cnt[d], p_g(d) + 1);
                end
            end
            bits_r[d] = {bits_r[d][30:0], mosi_v[d]};
            nbits[d]++;
            chk(d, ready_v[d] == 1'b0, "ready_in_frame", ready_v[d], 0);
            chk(d, ldac_v[d] == 1'b1, "ldac_in_frame", ldac_v[d], 1);
        end else begin
            if (in_frame[d] != 0) begin
                in_frame[d] = 0;
                if (abort_flag[d] != 0) begin
                    abort_flag[d] = 0;
                    if (qsize(d) > 0) pop(d, e);
                    have_prev[d] = 0;
                    pend_ldac[d] = 0;
                end else begin
                    chk(d, nbits[d] == 32, "cs_low_len", nbits[d], 32);
                    if (qsize(d) == 0) begin
                        chk(d, 1'b0, "unexpected_frame", bits_r[d], 0);
                        pend_ldac[d] = 0;
                    end else begin
                        pop(d, e);
                        chk(d, bits_r[d] == e.frame, "frame", bits_r[d], e.frame);
                        pend_ldac[d] = int'(e.ldac);
                    end
                    have_prev[d] = 1;
                end
                high_cnt[d] = 0;
            end
            high_cnt[d]++;
            ldac_exp = (pend_ldac[d] != 0) && (high_cnt[d] == p_g(d) + 1);
            chk(d, ldac_v[d] == !ldac_exp, "ldac_n", ldac_v[d], !ldac_exp);
            chk(d, mosi_v[d] == 1'b0, "mosi_idle", mosi_v[d], 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge sclk);
            for (int d = 0; d < 2; d++) mon_step(d);
        end
    end

    initial begin
        int w;
        rst_v   = 2'b11;
        en_v    = 2'b11;
        valid_v = 2'b00;
        data_v  = '0;
        ch_v    = '0;
        err_v   = '0;
        repeat (3) @(posedge sclk);
        #1;
        check_reset_vals(0);
        check_reset_vals(1);
        @(negedge sclk);
        rst_v = 2'b00;
        @(posedge sclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d, clr_v[d] == 1'b1,   "clr_release", clr_v[d], 1);
            chk(d, ready_v[d] == 1'b1, "ready_idle",  ready_v[d], 1);
        end
        @(negedge sclk);

        // DUT A: single frame, back-to-back extremes, drops
        send(0, 0, 1, 0, 0);
        send(0, 12'h800, 0, 0, 1);
        send(0, 12'h7FF, 0, 0, 1);
        valid_v[0] = 1'b0;
        @(negedge sclk);
        #1;
        chk(0, last_gap[0] == 3, "b2b_gap", last_gap[0], 3);
        send(0, 5, 0, 1, 0);
        #1;
        chk(0, ready_v[0] == 1'b1, "ready_after_drop", ready_v[0], 1);
        send(0, 5, 3, 0, 0);

        // DUT A: reset while bit 10 is on the wire
        send(0, 12'h5A5, 1, 0, 0);
        repeat (22) @(negedge sclk);
        abort_flag[0] = 1;
        rst_v[0] = 1'b1;
        @(posedge sclk);
        #1;
        check_reset_vals(0);
        model_drop[0] = 0;
        @(negedge sclk);
        rst_v[0] = 1'b0;
        @(posedge sclk);
        #1;
        chk(0, clr_v[0] == 1'b1, "clr_after_reset", clr_v[0], 1);
        @(negedge sclk);
        send(0, 100, 1, 0, 0);

        rand_run(0, 40);
        for (int i = 0; i < 300; i++) send(0, 0, 0, 2, 1);
        valid_v[0] = 1'b0;
        chk(0, drop_a == 8'd255, "drop_saturate", drop_a, 255);

        // DUT B: LDAC only after last channel; en drop mid-frame
        send(1, 100, 0, 0, 0);
        send(1, 200, 1, 0, 0);
        send(1, 300, 2, 0, 0);
        send(1, 16'h7FFF, 0, 0, 0);
        repeat (5) @(negedge sclk);
        en_v[1]    = 1'b0;
        data_v[1]  = 16'h1234;
        ch_v[1]    = 2'd1;
        err_v[1]   = 2'd0;
        valid_v[1] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge sclk);
            #1;
            chk(1, ready_v[1] == 1'b0, "ready_en_low", ready_v[1], 0);
        end
        chk(1, busy_v[1] == 1'b0, "frame_done_en_low", busy_v[1], 0);
        en_v[1] = 1'b1;
        send(1, 16'h1234, 1, 0, 0);
        send(1, 7, 3, 0, 0);
        rand_run(1, 40);

        w = 0;
        while ((qsize(0) + qsize(1) + in_frame[0] + in_frame[1]) != 0 && w < 500) begin
            @(negedge sclk);
            w++;
        end
        repeat (10) @(negedge sclk);
        chk(0, qsize(0) == 0 && in_frame[0] == 0, "drain", qsize(0), 0);
        chk(1, qsize(1) == 0 && in_frame[1] == 0, "drain", qsize(1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
